mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 256-bit memory port between two requesters.
- Port 0 is the display fetch path (high priority). Port 1 is a frame-write/host path (low priority, starvation-protected).
- Sequences one transaction at a time: latch, issue, wait for mem_ready_data, respond.
- Sits between the display main logic / writer and the memory controller port; the memory controller adds no base offset.

Parameters:
- MAX_P0_RUN, 8: consecutive port-0 grants allowed while port 1 is pending before port 1 is forced. Range 1..255.
- TIMEOUT, 1023: cycles in BUSY without mem_ready_data before the transaction is aborted. 0 disables the timeout. 10-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_req  in  1  port 0 request; held until p0_done
- p0_rw  in  1  port 0 direction: 1 = read, 0 = write
- p0_addr  in  28  port 0 address
- p0_wdata  in  256  port 0 write data
- p0_done  out  1  port 0 completion pulse (1 cycle)
- p0_err  out  1  port 0 timeout flag; valid with p0_done
- p1_req, p1_rw, p1_addr, p1_wdata, p1_done, p1_err: same as port 0, for port 1
- rd_data  out  256  captured read data; valid from a done pulse until the next capture
- data_rd  in  256  memory read data; valid when mem_ready_data = 1
- mem_ready_data  in  1  memory completion strobe
- mem_valid_data  out  1  transaction request to memory
- mem_rw_data  out  1  direction to memory: 1 = read
- mem_data_addr  out  28  address to memory
- data_wr  out  256  write data to memory
- grant_id  out  1  owner of the current or last transaction

Behaviour:
- Reset (rst = 1 at a clk edge):
  - State goes to IDLE.
  - Every output goes to 0, including rd_data and grant_id.
  - Run and timeout counters clear.
  - Reset mid-transaction drops the transaction silently: no done pulse, mem_valid_data = 0 on the next cycle.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a port.
  - Latch that port's addr, rw and wdata into mem_data_addr, mem_rw_data and data_wr. Set grant_id.
  - Assert mem_valid_data. Go to BUSY.
  - Request seen in cycle t gives mem_valid_data = 1 in cycle t+1.
- Selection:
  - Port 0 wins, unless p1_req = 1 and run_cnt >= MAX_P0_RUN; then port 1 wins.
  - run_cnt increments on each port-0 grant made while p1_req = 1, saturating at 255.
  - run_cnt clears on a port-1 grant, or in any IDLE cycle with p1_req = 0.
- BUSY:
  - mem_valid_data and all latched outputs are held stable.
  - On mem_ready_data = 1: if rw = read, capture data_rd into rd_data. Deassert mem_valid_data. Go to RESP.
  - Ready at cycle t+1+k gives done at t+2+k, with rd_data already valid that cycle.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT with no ready (TIMEOUT != 0), deassert mem_valid_data, set err for the owner, go to RESP. rd_data is unchanged.
  - If ready arrives in the same cycle the counter hits TIMEOUT, ready wins: err = 0.
- RESP:
  - Owner's done pulses 1 cycle. err is valid only in this cycle, 0 otherwise.
  - mem_valid_data = 0. Timeout counter clears. Go to IDLE.
- Requester rules:
  - Drop req in the cycle done is seen, or the next IDLE cycle treats it as a new request.
  - Deasserting req while BUSY does not cancel; done still pulses.
  - Changing addr/rw/wdata after grant has no effect (values are latched).
- mem_ready_data in IDLE or RESP is ignored: no state change, no capture.
- Minimum spacing between consecutive mem_valid_data assertions is 2 low cycles (RESP + IDLE).
- Both ports requesting in the same cycle resolves by the selection rule; the loser waits with no change.

Test Plan:
- Single read on port 0: p0_req = 1, p0_rw = 1, p0_addr = 0x0000100, memory ready after 3 cycles with data_rd = 0xA5..A5 -> mem_valid_data high 4 cycles, mem_data_addr = 0x0000100, p0_done pulses 1 cycle later, rd_data = 0xA5..A5, p0_err = 0.
- Port 1 write: p1_wdata = 0x1234 (zero-extended), p1_addr = 0x0FFFFFF, mem_rw_data = 0 -> data_wr = 0x1234, p1_done pulses, rd_data unchanged.
- Starvation: p0_req and p1_req held high continuously, MAX_P0_RUN = 8 -> grant sequence is 8x port 0, 1x port 1, then repeats. No port-1 wait exceeds 8 transactions.
- Timeout: TIMEOUT = 16, mem_ready_data never asserted -> mem_valid_data drops after 16 BUSY cycles, owner done = 1 with err = 1. A ready arriving on the 16th cycle gives err = 0.
- Reset mid-BUSY: rst = 1 for 1 cycle during BUSY -> next cycle all outputs 0, no done pulse, a late mem_ready_data is ignored, the next request proceeds normally.
- Spurious ready in IDLE with data_rd = 0xFF..FF -> rd_data stays at its prior value, no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared 256-bit memory port: port 0 (display fetch) has
// priority, port 1 is forced after MAX_P0_RUN back-to-back port-0 grants. One transaction at a time.
module mem_port_arbiter #(
  parameter int MAX_P0_RUN = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p0_rw,
  input  logic [27:0]  p0_addr,
  input  logic [255:0] p0_wdata,
  output logic         p0_done,
  output logic         p0_err,
  input  logic         p1_req,
  input  logic         p1_rw,
  input  logic [27:0]  p1_addr,
  input  logic [255:0] p1_wdata,
  output logic         p1_done,
  output logic         p1_err,
  output logic [255:0] rd_data,
  input  logic [255:0] data_rd,
  input  logic         mem_ready_data,
  output logic         mem_valid_data,
  output logic         mem_rw_data,
  output logic [27:0]  mem_data_addr,
  output logic [255:0] data_wr,
  output logic         grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic         rw;
    logic [27:0]  addr;
    logic [255:0] wdata;
  } req_t;

  localparam logic [7:0] RUN_MAX = 8'(MAX_P0_RUN);
  localparam logic [9:0] TO_LAST = (TIMEOUT == 0) ? 10'd0 : 10'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] run_cnt;
  logic [9:0] tcnt;
  logic       sel_p1;
  logic       timeout_hit;
  req_t       sel_req;

  // Port 1 wins only when port 0 is idle or port 0 has used up its run budget.
  assign sel_p1      = p1_req && (!p0_req || (run_cnt >= RUN_MAX));
  assign sel_req     = sel_p1 ? '{p1_rw, p1_addr, p1_wdata} : '{p0_rw, p0_addr, p0_wdata};
  // tcnt counts completed BUSY cycles, so the TIMEOUT-th BUSY cycle sees TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p0_req || p1_req) state_nxt = BUSY;
      BUSY:    if (mem_ready_data || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      run_cnt        <= '0;
      tcnt           <= '0;
      p0_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_done        <= 1'b0;
      p1_err         <= 1'b0;
      rd_data        <= '0;
      mem_valid_data <= 1'b0;
      mem_rw_data    <= 1'b0;
      mem_data_addr  <= '0;
      data_wr        <= '0;
      grant_id       <= 1'b0;
    end else begin
      state   <= state_nxt;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (p0_req || p1_req) begin
            mem_rw_data    <= sel_req.rw;
            mem_data_addr  <= sel_req.addr;
            data_wr        <= sel_req.wdata;
            grant_id       <= sel_p1;
            mem_valid_data <= 1'b1;
          end
          if (!p1_req || sel_p1)
            run_cnt <= '0;
          else if (run_cnt != 8'hFF)
            run_cnt <= run_cnt + 8'd1;
        end
        BUSY: begin
          tcnt <= tcnt + 10'd1;
          if (mem_ready_data) begin
            mem_valid_data <= 1'b0;
            if (mem_rw_data) rd_data <= data_rd;
            p0_done <= !grant_id;
            p1_done <= grant_id;
          end else if (timeout_hit) begin
            mem_valid_data <= 1'b0;
            p0_done <= !grant_id;
            p1_done <= grant_id;
            p0_err  <= !grant_id;
            p1_err  <= grant_id;
          end
        end
        RESP: tcnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized checks of mem_port_arbiter against a transaction-level model
// of grant order, latched request fields, completion latency, timeout and read-data capture.
module tb_mem_port_arbiter;
  localparam int MAXR = 8;
  localparam int TO   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_req, p0_rw, p1_req, p1_rw;
  logic [27:0]  p0_addr, p1_addr;
  logic [255:0] p0_wdata, p1_wdata;
  logic         p0_done, p0_err, p1_done, p1_err;
  logic [255:0] rd_data, data_rd, data_wr;
  logic         mem_ready_data, mem_valid_data, mem_rw_data, grant_id;
  logic [27:0]  mem_data_addr;

  int           vectors = 0;
  int           miscompares = 0;
  int           run_m = 0;        // port-0 grants in a row while port 1 waits
  logic [255:0] rd_m = '0;        // last captured read data

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_P0_RUN(MAXR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_err(p1_err),
    .rd_data(rd_data), .data_rd(data_rd), .mem_ready_data(mem_ready_data),
    .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data),
    .mem_data_addr(mem_data_addr), .data_wr(data_wr), .grant_id(grant_id)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
    $fatal(1);
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. k = BUSY cycles before ready (ready lands on BUSY cycle k+1);
  // k < 0 or k >= TO means memory never answers and the timeout must fire.
  task automatic txn(input logic r0, input logic r1, input logic rw0, input logic rw1,
                     input logic [27:0] a0, input logic [27:0] a1,
                     input logic [255:0] w0, input logic [255:0] w1,
                     input int k, input logic [255:0] rv);
    logic         w, wrw, rdy;
    logic [27:0]  wa;
    logic [255:0] wwd;
    int           lat;
    chk("idle_valid", mem_valid_data, 0);
    p0_req = r0; p0_rw = rw0; p0_addr = a0; p0_wdata = w0;
    p1_req = r1; p1_rw = rw1; p1_addr = a1; p1_wdata = w1;
    mem_ready_data = 1'b0;
    w = r1 && (!r0 || run_m >= MAXR);
    if (w || !r1) run_m = 0;
    else if (run_m < 255) run_m++;
    wrw = w ? rw1 : rw0;
    wa  = w ? a1 : a0;
    wwd = w ? w1 : w0;
    step();
    chk("grant_valid", mem_valid_data, 1);
    chk("grant_id", grant_id, w);
    chk("grant_addr", mem_data_addr, wa);
    chk("grant_rw", mem_rw_data, wrw);
    chk("grant_wdata", data_wr, wwd);
    // fields must stay latched even if the requester changes them
    if (w) begin p1_addr = 28'($urandom); p1_wdata = rnd256(); p1_rw = ~p1_rw; end
    else   begin p0_addr = 28'($urandom); p0_wdata = rnd256(); p0_rw = ~p0_rw; end
    rdy = (k >= 0) && (k < TO);
    lat = rdy ? k : TO - 1;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("busy_valid", mem_valid_data, 1);
      chk("busy_addr", mem_data_addr, wa);
      chk("busy_done", {p0_done, p1_done}, 2'b00);
    end
    chk("busy_wdata", data_wr, wwd);
    mem_ready_data = rdy;
    data_rd = rv;
    step();
    if (rdy && wrw) rd_m = rv;
    chk("done", {p0_done, p1_done}, w ? 2'b01 : 2'b10);
    chk("err", {p0_err, p1_err}, rdy ? 2'b00 : (w ? 2'b01 : 2'b10));
    chk("resp_rd_data", rd_data, rd_m);
    chk("resp_valid", mem_valid_data, 0);
    // ready during RESP must be ignored
    mem_ready_data = 1'($urandom_range(0, 1));
    data_rd = rnd256();
    if (w) p1_req = 1'b0; else p0_req = 1'b0;
    step();
    mem_ready_data = 1'b0;
    chk("post_done", {p0_done, p1_done, p0_err, p1_err}, 4'b0000);
    chk("post_rd_data", rd_data, rd_m);
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_rw = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_rw = 0; p1_addr = '0; p1_wdata = '0;
    mem_ready_data = 0; data_rd = '0;
    step(); step();
    chk("rst_valid", mem_valid_data, 0);
    chk("rst_flags", {p0_done, p0_err, p1_done, p1_err, grant_id, mem_rw_data}, 6'b0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr", mem_data_addr, 0);
    chk("rst_wdata", data_wr, 0);
    rst = 1'b0;
    step();

    // single port-0 read, ready after 3 cycles
    txn(1, 0, 1, 0, 28'h0000100, 28'h0, '0, '0, 3, {32{8'hA5}});
    // port-1 write, rd_data must be preserved
    txn(0, 1, 0, 0, 28'h0, 28'h0FFFFFF, '0, 256'h1234, 2, rnd256());

    // spurious ready in IDLE
    mem_ready_data = 1'b1;
    data_rd = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_rd_data", rd_data, rd_m);
      chk("spur_done", {p0_done, p1_done}, 2'b00);
      chk("spur_valid", mem_valid_data, 0);
    end
    mem_ready_data = 1'b0;
    step();

    // timeout, then ready exactly on the last allowed BUSY cycle
    txn(1, 0, 1, 0, 28'h0000200, '0, '0, '0, -1, rnd256());
    txn(0, 1, 1, 1, '0, 28'h0000300, '0, '0, TO - 1, rnd256());
    txn(1, 0, 1, 0, 28'h0000400, '0, '0, '0, TO, rnd256());

    // both ports held: 8x port 0 then 1x port 1, twice
    for (int i = 0; i < 18; i++)
      txn(1, 1, 1'($urandom), 1'($urandom), 28'($urandom), 28'($urandom),
          rnd256(), rnd256(), int'($urandom_range(0, 3)), rnd256());

    // reset in the middle of BUSY
    p0_req = 1; p0_rw = 1; p0_addr = 28'h0000ABC; p1_req = 0;
    step();
    chk("rstmid_grant", mem_valid_data, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0_req = 0;
    chk("rstmid_valid", mem_valid_data, 0);
    chk("rstmid_flags", {p0_done, p0_err, p1_done, p1_err, grant_id, mem_rw_data}, 6'b0);
    chk("rstmid_rd_data", rd_data, 0);
    chk("rstmid_addr", mem_data_addr, 0);
    rd_m = '0;
    run_m = 0;
    mem_ready_data = 1'b1;
    data_rd = rnd256();
    step();
    mem_ready_data = 1'b0;
    chk("late_ready_done", {p0_done, p1_done}, 2'b00);
    chk("late_ready_rd", rd_data, 0);
    txn(1, 0, 1, 0, 28'h0000500, '0, '0, '0, 1, rnd256());

    // random mix of requesters, directions and latencies
    for (int i = 0; i < 60; i++) begin
      logic r0, r1;
      int   k;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                      : int'($urandom_range(0, 6));
      txn(r0, r1, 1'($urandom), 1'($urandom), 28'($urandom), 28'($urandom),
          rnd256(), rnd256(), k, rnd256());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
